rx_deserializer: RTL
====================

# rx_deserializer

Receive-side stage directly downstream of the bit sampler in the serial transceiver. Consumes the sampler's one-cycle mid-bit strobes together with the serial line, and assembles 8 data bits per frame, LSB first. Checks the stop bit one bit-time after the last data bit. Pushes good bytes into a small FIFO that the consumer drains through a valid/ready handshake, and reports framing and overrun errors as sticky flags.

## Interface
- `SAMPLE_RATIO`, 16: sample-clock cycles per bit. Must match the sampler; range 4..16.
- `FIFO_DEPTH`, 4: receive FIFO entries. Must be a power of two, range 2..16.
- `sample_clk` input 1: the single clock. All logic is on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `din` input 1: serial line, the same net that feeds the sampler; idle high.
- `sample_sig` input 1: one-cycle strobe at the centre of each data bit, 8 strobes per frame.
- `rx_data` output 8: byte at the FIFO head; valid only while `rx_valid` is high.
- `rx_valid` output 1: FIFO not empty.
- `rx_ready` input 1: consumer accepts the head byte in any cycle where `rx_valid && rx_ready`.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `frame_err` output 1: sticky; set when a stop bit samples 0.
- `overrun` output 1: sticky; set when a good byte arrives while the FIFO is full and no pop occurs.
- `clear_err` input 1: clears both sticky flags.

## Operation
- FSM states:
  - COLLECT, the reset state. On each `sample_sig`, shift `din` into bit 7 of the shift register, shifting right; bit_cnt increments. On the strobe where bit_cnt==7, clear bit_cnt, clear the stop timer and go to STOP_WAIT.
  - STOP_WAIT: the stop timer increments each cycle. When it reaches SAMPLE_RATIO-1, sample `din` and go to COLLECT.
    - If `din`==1, push the shift register to the FIFO.
    - If `din`==0, discard the byte and set `frame_err`.
- `sample_sig` asserted during STOP_WAIT is ignored. No shift, no count.
- Bit order: the first strobe is `rx_data[0]` and the eighth is `rx_data[7]`.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - Occupancy counter 0..FIFO_DEPTH.
  - `rx_data` is driven from the entry at the read pointer.
- Push while the FIFO is full:
  - With a pop in the same cycle: both happen, the count is unchanged, no overrun.
  - Without a pop: the byte is dropped, `overrun` is set and the FIFO is unchanged.
- Pop while empty is impossible, because `rx_valid` is low.
- Push and pop in the same cycle on a non-full FIFO: the count is unchanged and both pointers advance.
- Sticky flags:
  - `clear_err` clears both flags.
  - If a set event and `clear_err` occur in the same cycle, set wins.
- Reset mid-frame: the partial byte, bit_cnt, timer, FIFO contents and flags are all discarded.
  - Re-alignment with the sampler is the system's job; both blocks are reset together.

## Timing
- Reset values: `rx_valid`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0, `rx_data`=8'h00, FSM in COLLECT, bit_cnt=0.
- Let the 8th strobe occur in cycle T.
  - Stop sample at cycle T+SAMPLE_RATIO (T+16 by default), which is the stop-bit centre.
  - The FIFO write and `frame_err` set take effect at that edge.
  - `rx_valid` is high from cycle T+SAMPLE_RATIO+1 if the FIFO was empty.
- `rx_data`, `rx_valid` and `fifo_count` are registered or derived only from registered state. There is no combinational path from `rx_ready` or `din` to any output.
- On a pop at edge E, the next entry (or `rx_valid`=0) appears in cycle E+1.
- Throughput: one frame per ≥10 bit-times. Minimum consumer rate to avoid overrun is 1 pop per 10·SAMPLE_RATIO cycles at steady state.

## Test plan
- Reset, then a frame of 0xA5 with stop=1 and `rx_ready`=1. Required:
  - `rx_valid` pulses for 1 cycle at T+17 with `rx_data`=8'hA5.
  - `fifo_count` goes 0→1→0.
  - No flags set.
- Frame of 0x3C with `din`=0 at the stop sample. Required: `frame_err`=1, `fifo_count` stays 0, `rx_valid` stays 0. Then `clear_err` for 1 cycle → `frame_err`=0.
- Send 5 frames 0x01..0x05 with `rx_ready`=0 and FIFO_DEPTH=4. Required:
  - `fifo_count`=4 and `overrun`=1 after the 5th frame.
  - Draining yields 0x01..0x04 in order, then `rx_valid`=0.
- FIFO full with `rx_ready`=1 in exactly the push cycle. Required: `overrun` stays 0, `fifo_count` stays 4, and the new byte is last in drain order.
- Extra `sample_sig` pulses injected during STOP_WAIT. Required: the byte is unchanged and the next frame is assembled correctly from its 8 strobes.
- `rst_n`=0 for 1 cycle after 4 strobes of a frame. Required: all outputs return to reset values, and the next 8 strobes assemble a fresh byte.

Source files
------------

// File: rtl/rx_deserializer.sv
// ============================================================================
//  Module   : rx_deserializer
//  Purpose  : Receive-side byte assembler. Collects 8 data bits (LSB first)
//             on the sampler's mid-bit strobes, checks the stop bit one
//             bit-time after the last data bit, and queues good bytes in a
//             small FIFO drained through a valid/ready handshake. Framing
//             and overrun errors are reported as sticky flags.
//  Ports    : sample_clk  - single clock, rising edge
//             rst_n       - synchronous active-low reset
//             din         - serial line (idle high)
//             sample_sig  - one-cycle strobe at each data-bit centre
//             rx_data     - byte at FIFO head (valid while rx_valid)
//             rx_valid    - FIFO not empty
//             rx_ready    - consumer accepts head byte when rx_valid
//             fifo_count  - number of occupied FIFO entries
//             frame_err   - sticky, stop bit sampled low
//             overrun     - sticky, good byte lost to a full FIFO
//             clear_err   - clears both sticky flags (set wins)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_deserializer #(
  parameter int SAMPLE_RATIO = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sample_clk,
  input  logic                          rst_n,
  input  logic                          din,
  input  logic                          sample_sig,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clear_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(SAMPLE_RATIO);

  localparam logic [TMR_W-1:0] STOP_AT  = TMR_W'(SAMPLE_RATIO - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [0:0] {
    COLLECT   = 1'b0,
    STOP_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic [TMR_W-1:0] timer;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic stop_hit;
  logic good_byte;
  logic bad_stop;
  logic pop;
  logic full;
  logic push;
  logic ovr_set;

  // Stop-bit centre: the cycle in which the timer holds SAMPLE_RATIO-1,
  // i.e. SAMPLE_RATIO cycles after the 8th strobe.
  assign stop_hit  = (state == STOP_WAIT) && (timer == STOP_AT);
  assign good_byte = stop_hit && din;
  assign bad_stop  = stop_hit && !din;

  assign pop      = rx_valid && rx_ready;
  assign full     = (fifo_count == FULL_CNT);
  // A full FIFO still accepts the byte if the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign push     = good_byte && (!full || pop);
  assign ovr_set  = good_byte && full && !pop;

  assign rx_valid = (fifo_count != '0);
  assign rx_data  = mem[rd_ptr];

  // Bit collection / stop-bit timing FSM
  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (sample_sig) begin
            shift_reg <= {din, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;  // wraps to 0 after the 8th bit
            if (bit_cnt == 3'd7) begin
              timer <= '0;
              state <= STOP_WAIT;
            end
          end
        end
        STOP_WAIT: begin
          // Strobes are ignored here: only the timer advances.
          if (timer == STOP_AT) begin
            state <= COLLECT;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Receive FIFO and sticky flags
  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shift_reg;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase

      if (bad_stop) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end

      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
